display_scan_capture: RTL and testbench

- Receive side of the multiplexed 4-digit 7-segment display bus that the elevator top level drives (segments A..G, P, DIG1..DIG4).
- Samples the scanned bus, waits for each digit strobe to settle, and decodes each glyph back to a 4-bit code.
- Commits the four digits as one coherent frame and flags stale or malformed scans.
- Used as a self-check and monitor next to the display driver: it recovers the floor and people-count shown on the display.

---
 rtl/display_scan_capture_pkg.sv | 41 ++++
 rtl/display_scan_capture_if.sv | 29 ++
 rtl/display_scan_capture_glyph_decoder.sv | 36 +++
 rtl/display_scan_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_display_scan_capture.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_capture_pkg.sv
// Shared types and constants for the 7-segment display scan capture block.
package display_scan_pkg;

  // Scan tracker states: waiting for a strobe, debouncing it, and holding after capture.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  // Active-high segment patterns, bit0 = A .. bit6 = G.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Codes reported for a dark digit and for a pattern that is not a known glyph.
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;

  // Number of active strobes, used to tell a clean strobe from an overlap.
  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/display_scan_capture_if.sv
// Bundle of the scanned display bus plus the recovered frame and status outputs.
interface display_scan_capture_if;

  logic [6:0]  seg_in;
  logic        dp_in;
  logic [3:0]  dig_in;
  logic        clear_err;

  logic [15:0] digits;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        frame_changed;
  logic        stale;
  logic        err_overlap;
  logic        err_glyph;

  // The display driver side (or a bench) drives the raw bus and watches the results.
  modport master (
    output seg_in, dp_in, dig_in, clear_err,
    input  digits, dp_out, frame_valid, frame_changed, stale, err_overlap, err_glyph
  );

  // The capture block consumes the raw bus and produces the results.
  modport slave (
    input  seg_in, dp_in, dig_in, clear_err,
    output digits, dp_out, frame_valid, frame_changed, stale, err_overlap, err_glyph
  );

endinterface

// File: rtl/display_scan_capture_glyph_decoder.sv
// Combinational 7-segment glyph to 4-bit code decoder.
module seg7_glyph_decoder
  import display_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       bad
);

  // Map each known lit-segment pattern to its code; anything unknown is flagged bad.
  always_comb begin
    code = CODE_BAD;
    bad  = 1'b0;
    case (pattern)
      GLYPH_0:     code = 4'h0;
      GLYPH_1:     code = 4'h1;
      GLYPH_2:     code = 4'h2;
      GLYPH_3:     code = 4'h3;
      GLYPH_4:     code = 4'h4;
      GLYPH_5:     code = 4'h5;
      GLYPH_6:     code = 4'h6;
      GLYPH_7:     code = 4'h7;
      GLYPH_8:     code = 4'h8;
      GLYPH_9:     code = 4'h9;
      GLYPH_A:     code = 4'hA;
      GLYPH_B:     code = 4'hB;
      GLYPH_C:     code = 4'hC;
      GLYPH_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_BAD;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/display_scan_capture.sv
// Recovers the four digits shown on a multiplexed 7-segment bus and commits them as frames.
module display_scan_capture
  import display_scan_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic                   clk,
  input logic                   reset,
  display_scan_capture_if.slave bus
);

  localparam int unsigned        TIMER_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX     = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]         SETTLE_TARGET = 9'(SETTLE_CYCLES);
  localparam logic [6:0]         SEG_IDLE      = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0]         DIG_IDLE      = {4{DIG_ACTIVE_LOW}};

  // Synchronizer stages, reset to the electrically idle level so nothing looks lit.
  logic [6:0] seg_meta_q, seg_sync_q;
  logic       dp_meta_q, dp_sync_q;
  logic [3:0] dig_meta_q, dig_sync_q;

  // Polarity-normalised (active-high) view of the synchronized bus.
  logic [6:0] seg_act;
  logic       dp_act;
  logic [3:0] dig_act;
  logic [7:0] pat_act;
  logic [2:0] strobe_count;
  logic       one_strobe;
  logic       overlap;

  // Scan tracker.
  scan_state_e state_q, state_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;

  // Shadow frame being assembled and the mask of digits captured so far.
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_code_q, shadow_code_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;

  // Committed frame and status.
  logic [15:0]        digits_q, digits_d;
  logic [3:0]         dp_out_q, dp_out_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_changed_q, frame_changed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               stale_q, stale_d;
  logic               err_overlap_q, err_overlap_d;
  logic               err_glyph_q, err_glyph_d;

  logic       capture;
  logic       commit;
  logic [3:0] dec_code;
  logic       dec_bad;

  // Two-flop synchronizer on every raw bus line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_meta_q <= SEG_IDLE;
      seg_sync_q <= SEG_IDLE;
      dp_meta_q  <= SEG_ACTIVE_LOW;
      dp_sync_q  <= SEG_ACTIVE_LOW;
      dig_meta_q <= DIG_IDLE;
      dig_sync_q <= DIG_IDLE;
    end else begin
      seg_meta_q <= bus.seg_in;
      seg_sync_q <= seg_meta_q;
      dp_meta_q  <= bus.dp_in;
      dp_sync_q  <= dp_meta_q;
      dig_meta_q <= bus.dig_in;
      dig_sync_q <= dig_meta_q;
    end
  end

  assign seg_act      = seg_sync_q ^ SEG_IDLE;
  assign dp_act       = dp_sync_q ^ SEG_ACTIVE_LOW;
  assign dig_act      = dig_sync_q ^ DIG_IDLE;
  assign pat_act      = {dp_act, seg_act};
  assign strobe_count = count_ones4(dig_act);
  assign one_strobe   = (strobe_count == 3'd1);
  assign overlap      = (strobe_count > 3'd1);

  // The decoder always looks at the latched pattern, which equals the live one on a capture cycle.
  seg7_glyph_decoder u_decoder (
    .pattern (pat_q[6:0]),
    .code    (dec_code),
    .bad     (dec_bad)
  );

  // Next-state logic: strobe tracking, shadow capture, frame commit, timeout and sticky errors.
  always_comb begin
    state_d         = state_q;
    strobe_d        = strobe_q;
    pat_d           = pat_q;
    settle_cnt_d    = settle_cnt_q;
    mask_d          = mask_q;
    shadow_code_d   = shadow_code_q;
    shadow_dp_d     = shadow_dp_q;
    digits_d        = digits_q;
    dp_out_d        = dp_out_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;
    timer_d         = timer_q;
    stale_d         = stale_q;
    capture         = 1'b0;
    commit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (one_strobe) begin
          state_d      = SETTLE;
          strobe_d     = dig_act;
          pat_d        = pat_act;
          settle_cnt_d = 8'd1;
        end
      end
      SETTLE: begin
        if ((dig_act == strobe_q) && (pat_act == pat_q)) begin
          if (({1'b0, settle_cnt_q} + 9'd1) >= SETTLE_TARGET) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if ((dig_act != strobe_q) || (pat_act != pat_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An overlapping strobe makes the whole scan untrustworthy, so it beats any capture or commit.
    if (overlap) begin
      state_d = IDLE;
      capture = 1'b0;
    end

    commit = (mask_q == 4'b1111) && !overlap;

    if (commit) begin
      digits_d        = shadow_code_q;
      dp_out_d        = shadow_dp_q;
      frame_valid_d   = 1'b1;
      frame_changed_d = (shadow_code_q != digits_q) || (shadow_dp_q != dp_out_q);
      mask_d          = 4'b0000;
    end

    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_q[i]) begin
          shadow_code_d[i*4 +: 4] = dec_code;
          shadow_dp_d[i]          = pat_q[7];
        end
      end
      mask_d = mask_d | strobe_q;
    end

    if (overlap) begin
      mask_d = 4'b0000;
    end

    if (commit) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    if (commit) begin
      stale_d = 1'b0;
    end else if (timer_d == TIMER_MAX) begin
      stale_d = 1'b1;
    end

    err_overlap_d = (err_overlap_q & ~bus.clear_err) | overlap;
    err_glyph_d   = (err_glyph_q & ~bus.clear_err) | (capture & dec_bad);
  end

  // State and frame registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      strobe_q        <= 4'b0000;
      pat_q           <= 8'h00;
      settle_cnt_q    <= 8'd0;
      mask_q          <= 4'b0000;
      shadow_code_q   <= 16'hFFFF;
      shadow_dp_q     <= 4'b0000;
      digits_q        <= 16'hFFFF;
      dp_out_q        <= 4'b0000;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      timer_q         <= '0;
      stale_q         <= 1'b1;
      err_overlap_q   <= 1'b0;
      err_glyph_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      strobe_q        <= strobe_d;
      pat_q           <= pat_d;
      settle_cnt_q    <= settle_cnt_d;
      mask_q          <= mask_d;
      shadow_code_q   <= shadow_code_d;
      shadow_dp_q     <= shadow_dp_d;
      digits_q        <= digits_d;
      dp_out_q        <= dp_out_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      timer_q         <= timer_d;
      stale_q         <= stale_d;
      err_overlap_q   <= err_overlap_d;
      err_glyph_q     <= err_glyph_d;
    end
  end

  assign bus.digits        = digits_q;
  assign bus.dp_out        = dp_out_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_changed = frame_changed_q;
  assign bus.stale         = stale_q;
  assign bus.err_overlap   = err_overlap_q;
  assign bus.err_glyph     = err_glyph_q;

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: drives active-low scans and scores committed frames.
`timescale 1ns/1ps
module tb_display_scan_capture;

  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 100;
  localparam int HOLD_CYC = 10;
  localparam int GAP_CYC  = 2;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
  localparam logic [6:0] G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07, G8 = 7'h7F, G9 = 7'h6F;
  localparam logic [6:0] GA = 7'h77, GB = 7'h7C, GC = 7'h39, GBL = 7'h00, GBAD = 7'h49;

  typedef struct {
    logic [27:0] glyphs;
    logic [3:0]  dps;
    logic [15:0] exp_digits;
    logic [3:0]  exp_dp;
    logic        exp_changed;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        changed;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  display_scan_capture_if bus();

  display_scan_capture #(
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   cycle_cnt    = 0;
  int   frames_seen  = 0;
  int   fv_cycle     = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus(input int n);
    bus.seg_in  = 7'h7F;
    bus.dp_in   = 1'b1;
    bus.dig_in  = 4'hF;
    repeat (n) tick();
  endtask

  // One scan of DIG1..DIG4; short_digit is held only SETTLE-1 cycles, clr_digit gets clear_err on its capture cycle.
  task automatic applyStimulus(input logic [27:0] glyphs, input logic [3:0] dps,
                               input int short_digit, input int clr_digit);
    for (int d = 0; d < 4; d++) begin
      int hold;
      hold = (d == short_digit) ? SETTLE - 1 : HOLD_CYC;
      bus.seg_in = ~glyphs[d*7 +: 7];
      bus.dp_in  = ~dps[d];
      bus.dig_in = ~(4'b0001 << d);
      for (int c = 0; c < hold; c++) begin
        bus.clear_err = (d == clr_digit) && (c == SETTLE + 1);
        tick();
      end
      bus.clear_err = 1'b0;
      idleBus(GAP_CYC);
    end
  endtask

  task automatic expectFrame(input logic [15:0] d, input logic [3:0] p, input logic ch);
    exp_t e;
    e.digits  = d;
    e.dp      = p;
    e.changed = ch;
    sb_q.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 50;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic pulseClear();
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    tick();
  endtask

  // Frame monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (bus.frame_valid === 1'b1) begin
        frames_seen++;
        fv_cycle = cycle_cnt;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("frame_digits", 32'(bus.digits), 32'(e.digits));
          checkOutput("frame_dp", 32'(bus.dp_out), 32'(e.dp));
          checkOutput("frame_changed", 32'(bus.frame_changed), 32'(e.changed));
          checkOutput("stale_on_commit", 32'(bus.stale), 32'd0);
        end
      end else if (bus.frame_changed === 1'b1) begin
        checkOutput("changed_without_valid", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int frames_before;
    int guard;

    vecs[0] = '{{G3, GBL, GBL, GA}, 4'b0000, 16'h3FFA, 4'b0000, 1'b1};
    vecs[1] = '{{G3, GBL, GBL, GA}, 4'b0000, 16'h3FFA, 4'b0000, 1'b0};
    vecs[2] = '{{GBL, GBL, GBL, GBL}, 4'b0000, 16'hFFFF, 4'b0000, 1'b1};
    vecs[3] = '{{G9, G8, G2, G1}, 4'b0010, 16'h9821, 4'b0010, 1'b1};
    vecs[4] = '{{G6, G5, G4, G0}, 4'b1000, 16'h6540, 4'b1000, 1'b1};
    vecs[5] = '{{G0, GC, GB, G7}, 4'b0000, 16'h0CB7, 4'b0000, 1'b1};
    vecs[6] = '{{G0, GC, GB, G7}, 4'b0001, 16'h0CB7, 4'b0001, 1'b1};

    reset         = 1'b0;
    bus.clear_err = 1'b0;
    idleBus(3);
    checkOutput("reset_digits", 32'(bus.digits), 32'hFFFF);
    checkOutput("reset_dp", 32'(bus.dp_out), 32'd0);
    checkOutput("reset_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("reset_changed", 32'(bus.frame_changed), 32'd0);
    checkOutput("reset_stale", 32'(bus.stale), 32'd1);
    checkOutput("reset_err_overlap", 32'(bus.err_overlap), 32'd0);
    checkOutput("reset_err_glyph", 32'(bus.err_glyph), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] table-driven scans");
    for (int i = 0; i < 7; i++) begin
      expectFrame(vecs[i].exp_digits, vecs[i].exp_dp, vecs[i].exp_changed);
      applyStimulus(vecs[i].glyphs, vecs[i].dps, -1, -1);
      waitDrain("drain_vector");
    end
    checkOutput("clean_err_glyph", 32'(bus.err_glyph), 32'd0);
    checkOutput("clean_err_overlap", 32'(bus.err_overlap), 32'd0);

    $display("[TB] short strobe on DIG2");
    frames_before = frames_seen;
    applyStimulus({G7, G7, G7, G7}, 4'b0000, 1, -1);
    idleBus(4);
    checkOutput("short_strobe_no_commit", 32'(frames_seen), 32'(frames_before));

    $display("[TB] overlapping strobes mid-frame");
    bus.seg_in = ~G5;
    bus.dp_in  = 1'b1;
    bus.dig_in = 4'b1110;
    repeat (HOLD_CYC) tick();
    bus.dig_in = 4'b1100;
    repeat (4) tick();
    idleBus(4);
    checkOutput("overlap_flag", 32'(bus.err_overlap), 32'd1);
    checkOutput("overlap_digits_kept", 32'(bus.digits), 32'h0CB7);
    checkOutput("overlap_dp_kept", 32'(bus.dp_out), 32'h1);
    checkOutput("overlap_no_commit", 32'(frames_seen), 32'(frames_before));
    expectFrame(16'h4321, 4'b0000, 1'b1);
    applyStimulus({G4, G3, G2, G1}, 4'b0000, -1, -1);
    waitDrain("drain_after_overlap");
    checkOutput("overlap_sticky", 32'(bus.err_overlap), 32'd1);
    pulseClear();
    checkOutput("overlap_cleared", 32'(bus.err_overlap), 32'd0);

    $display("[TB] undecodable glyph on DIG3");
    expectFrame(16'h3E21, 4'b0000, 1'b1);
    applyStimulus({G3, GBAD, G2, G1}, 4'b0000, -1, -1);
    waitDrain("drain_bad_glyph");
    checkOutput("bad_glyph_flag", 32'(bus.err_glyph), 32'd1);
    pulseClear();
    checkOutput("bad_glyph_cleared", 32'(bus.err_glyph), 32'd0);
    expectFrame(16'h3E21, 4'b0000, 1'b0);
    applyStimulus({G3, GBAD, G2, G1}, 4'b0000, -1, 2);
    waitDrain("drain_bad_glyph_clear");
    checkOutput("clear_vs_new_error", 32'(bus.err_glyph), 32'd1);

    $display("[TB] timeout after last commit");
    @(negedge clk);
    guard = 0;
    while ((cycle_cnt < fv_cycle + TIMEOUT - 1) && (guard < 1000)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("timeout_wait_cycle", 32'(cycle_cnt - fv_cycle), 32'(TIMEOUT - 1));
    checkOutput("stale_before_limit", 32'(bus.stale), 32'd0);
    @(negedge clk);
    checkOutput("stale_at_limit", 32'(bus.stale), 32'd1);
    tick();
    expectFrame(16'h8888, 4'b0000, 1'b1);
    applyStimulus({G8, G8, G8, G8}, 4'b0000, -1, -1);
    waitDrain("drain_after_timeout");
    checkOutput("stale_after_commit", 32'(bus.stale), 32'd0);

    $display("[TB] reset in the middle of a scan");
    bus.seg_in = ~G8;
    bus.dp_in  = 1'b1;
    bus.dig_in = 4'b1110;
    repeat (6) tick();
    reset = 1'b0;
    #2;
    checkOutput("midreset_digits", 32'(bus.digits), 32'hFFFF);
    checkOutput("midreset_dp", 32'(bus.dp_out), 32'd0);
    checkOutput("midreset_stale", 32'(bus.stale), 32'd1);
    checkOutput("midreset_err_glyph", 32'(bus.err_glyph), 32'd0);
    checkOutput("midreset_valid", 32'(bus.frame_valid), 32'd0);
    idleBus(2);
    reset = 1'b1;
    tick();
    expectFrame(16'h8888, 4'b0000, 1'b1);
    applyStimulus({G8, G8, G8, G8}, 4'b0000, -1, -1);
    waitDrain("drain_after_reset");

    idleBus(3);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
